// File: rtl/compmag_arb.sv
// Round-robin sharing of one external magnitude comparator among NREQ requesters; optional flag checker via COMPMAG_ARB_CHECK_EN.
// Latency: grant edge -> SETTLE cycle -> ACK cycle (one compare per 3 cycles); requesters are held off by holding req until ack.
module compmag_arb #(
    parameter int WIDTH = 7,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       ack,
    output logic                  res_eq,
    output logic                  res_gt,
    output logic                  res_lt,
    output logic                  busy,
    output logic [WIDTH-1:0]      cmp_a,
    output logic [WIDTH-1:0]      cmp_b,
    input  logic                  cmp_aeqb,
    input  logic                  cmp_agtb,
    input  logic                  cmp_altb
`ifdef COMPMAG_ARB_CHECK_EN
    ,
    output logic                  err,
    output logic [7:0]            err_cnt
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gnt_q, gnt_d;
    logic [WIDTH-1:0] cmp_a_q, cmp_a_d;
    logic [WIDTH-1:0] cmp_b_q, cmp_b_d;
    logic [2:0]       res_q, res_d;

    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = a_in[i*WIDTH +: WIDTH];
        assign b_arr[i] = b_in[i*WIDTH +: WIDTH];
    end

    // Search starts one past the last grant, so the most recently served requester is lowest priority.
    logic          gnt_found;
    logic [PW-1:0] gnt_idx;
    int            idx;
    logic [PW-1:0] idx_w;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        idx       = 0;
        idx_w     = '0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_w = PW'(idx);
            if (!gnt_found && req[idx_w]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx_w;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cmp_a_d = cmp_a_q;
        cmp_b_d = cmp_b_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    gnt_d   = gnt_idx;
                    ptr_d   = gnt_idx;
                    cmp_a_d = a_arr[gnt_idx];
                    cmp_b_d = b_arr[gnt_idx];
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                res_d   = {cmp_aeqb, cmp_agtb, cmp_altb};
                state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NREQ - 1);
            gnt_q   <= '0;
            cmp_a_q <= '0;
            cmp_b_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cmp_a_q <= cmp_a_d;
            cmp_b_q <= cmp_b_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        ack = '0;
        if (state_q == ACK) ack[gnt_q] = 1'b1;
    end

    assign busy   = (state_q != IDLE);
    assign cmp_a  = cmp_a_q;
    assign cmp_b  = cmp_b_q;
    assign res_eq = res_q[2];
    assign res_gt = res_q[1];
    assign res_lt = res_q[0];

`ifdef COMPMAG_ARB_CHECK_EN
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [2:0] ref_flags;
    logic       flag_bad;

    // The reference is always one-hot, so any mismatch also covers non-one-hot comparator flags.
    always_comb begin
        ref_flags = {cmp_a_q == cmp_b_q, cmp_a_q > cmp_b_q, cmp_a_q < cmp_b_q};
        flag_bad  = ({cmp_aeqb, cmp_agtb, cmp_altb} != ref_flags);
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (state_q == SETTLE && flag_bad) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_compmag_arb.sv
// Bench for compmag_arb: directed scenarios plus a randomized run against a transaction-level round-robin model.
module tb_compmag_arb;
    localparam int WIDTH = 7;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in, b_in;
    logic [NREQ-1:0]       ack;
    logic                  res_eq, res_gt, res_lt, busy;
    logic [WIDTH-1:0]      cmp_a, cmp_b;
    logic                  cmp_aeqb, cmp_agtb, cmp_altb;
    logic                  force_en;
    logic [2:0]            force_flags;
`ifdef COMPMAG_ARB_CHECK_EN
    logic                  err;
    logic [7:0]            err_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External comparator, with an override to inject bad flags.
    assign cmp_aeqb = force_en ? force_flags[2] : (cmp_a == cmp_b);
    assign cmp_agtb = force_en ? force_flags[1] : (cmp_a > cmp_b);
    assign cmp_altb = force_en ? force_flags[0] : (cmp_a < cmp_b);

    compmag_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .ack(ack), .res_eq(res_eq), .res_gt(res_gt), .res_lt(res_lt), .busy(busy),
        .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_aeqb(cmp_aeqb), .cmp_agtb(cmp_agtb), .cmp_altb(cmp_altb)
`ifdef COMPMAG_ARB_CHECK_EN
        , .err(err), .err_cnt(err_cnt)
`endif
    );

    function automatic logic [2:0] exp_flags(input int a, input int b);
        return {a == b, a > b, a < b};
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int off = 1; off <= NREQ; off++) begin
            if (r[(last + off) % NREQ]) return (last + off) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_op(input int i, input int a, input int b);
        a_in[i*WIDTH +: WIDTH] = WIDTH'(a);
        b_in[i*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns the first nonzero ack (or 0 on timeout), negedges waited and busy cycles seen.
    task automatic wait_ack(output logic [NREQ-1:0] seen, output int cyc, output int bcyc);
        seen = '0; cyc = 0; bcyc = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            cyc++;
            if (busy) bcyc++;
            if (ack != '0) begin
                seen = ack;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; a_in = '0; b_in = '0; force_en = 1'b0; force_flags = '0;
        @(negedge clk);
        checks++; if (ack !== '0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({cmp_a, cmp_b} !== '0) begin failures++; $display("FAIL reset_cmp got=%0d/%0d exp=0/0", cmp_a, cmp_b); end
        checks++; if ({res_eq, res_gt, res_lt} !== 3'b000) begin failures++; $display("FAIL reset_res got=%b exp=000", {res_eq, res_gt, res_lt}); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [NREQ-1:0] seen; int cyc, bcyc;
        do_reset();
        set_op(0, 25, 100);
        req = 4'b0001;
        wait_ack(seen, cyc, bcyc);
        checks++; if (seen !== 4'b0001) begin failures++; $display("FAIL single_ack got=%b exp=0001", seen); end
        checks++; if (cyc != 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", cyc); end
        checks++; if (bcyc != 2) begin failures++; $display("FAIL single_busy got=%0d exp=2", bcyc); end
        checks++; if ({res_eq, res_gt, res_lt} !== exp_flags(25, 100)) begin failures++; $display("FAIL single_res got=%b exp=001", {res_eq, res_gt, res_lt}); end
        req = '0;
        @(negedge clk);
        checks++; if ({busy, ack} !== '0) begin failures++; $display("FAIL single_idle got=%b/%b exp=0/0", busy, ack); end
    endtask

    task automatic test_equal();
        logic [NREQ-1:0] seen; int cyc, bcyc;
        set_op(2, 127, 127);
        req = 4'b0100;
        wait_ack(seen, cyc, bcyc);
        checks++; if (seen !== 4'b0100) begin failures++; $display("FAIL equal_ack got=%b exp=0100", seen); end
        checks++; if ({res_eq, res_gt, res_lt} !== 3'b100) begin failures++; $display("FAIL equal_res got=%b exp=100", {res_eq, res_gt, res_lt}); end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_all_four();
        logic [NREQ-1:0] seen; int cyc, bcyc;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, i + 10, 12);
        req = '1;
        for (int k = 0; k < NREQ; k++) begin
            wait_ack(seen, cyc, bcyc);
            checks++; if (seen !== NREQ'(1 << k)) begin failures++; $display("FAIL all4_order k=%0d got=%b exp=%b", k, seen, NREQ'(1 << k)); end
            checks++; if (cyc != ((k == 0) ? 2 : 3)) begin failures++; $display("FAIL all4_spacing k=%0d got=%0d exp=%0d", k, cyc, (k == 0) ? 2 : 3); end
            checks++; if ({res_eq, res_gt, res_lt} !== exp_flags(k + 10, 12)) begin failures++; $display("FAIL all4_res k=%0d got=%b exp=%b", k, {res_eq, res_gt, res_lt}, exp_flags(k + 10, 12)); end
            req[k] = 1'b0;
        end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] seen, exp; int cyc, bcyc;
        do_reset();
        set_op(0, 1, 2);
        set_op(3, 9, 4);
        req = 4'b1001;
        for (int k = 0; k < 6; k++) begin
            wait_ack(seen, cyc, bcyc);
            exp = (k % 2 == 0) ? 4'b0001 : 4'b1000;
            checks++; if (seen !== exp) begin failures++; $display("FAIL fair_grant k=%0d got=%b exp=%b", k, seen, exp); end
            checks++; if (cyc != ((k == 0) ? 2 : 3)) begin failures++; $display("FAIL fair_spacing k=%0d got=%0d exp=%0d", k, cyc, (k == 0) ? 2 : 3); end
            checks++; if ({res_eq, res_gt, res_lt} !== ((k % 2 == 0) ? exp_flags(1, 2) : exp_flags(9, 4))) begin failures++; $display("FAIL fair_res k=%0d got=%b", k, {res_eq, res_gt, res_lt}); end
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] seen; int cyc, bcyc;
        do_reset();
        set_op(1, 60, 30);
        req = 4'b0010;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_settle got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if ({ack, busy} !== '0) begin failures++; $display("FAIL midrst_outs got=%b/%b exp=0/0", ack, busy); end
        checks++; if ({cmp_a, cmp_b, res_eq, res_gt, res_lt} !== '0) begin failures++; $display("FAIL midrst_regs got=%0d/%0d/%b exp=0", cmp_a, cmp_b, {res_eq, res_gt, res_lt}); end
        @(negedge clk);
        checks++; if (ack !== '0) begin failures++; $display("FAIL midrst_noack got=%b exp=0", ack); end
        rst_n = 1'b1;
        wait_ack(seen, cyc, bcyc);
        checks++; if (seen !== 4'b0010) begin failures++; $display("FAIL midrst_regrant got=%b exp=0010", seen); end
        checks++; if ({res_eq, res_gt, res_lt} !== 3'b010) begin failures++; $display("FAIL midrst_res got=%b exp=010", {res_eq, res_gt, res_lt}); end
        req = 4'b0001;
        set_op(0, 3, 3);
        wait_ack(seen, cyc, bcyc);
        checks++; if (seen !== 4'b0001) begin failures++; $display("FAIL midrst_next got=%b exp=0001", seen); end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [NREQ-1:0] r, exp_ack;
        logic [2:0]      exp_res;
        logic            exp_busy;
        int stage, last, g, a, b, maxwait, ack_errs;
        int waitc [NREQ];
        do_reset();
        stage = 0; last = NREQ - 1; g = 0; exp_res = '0; maxwait = 0; ack_errs = 0;
        for (int i = 0; i < NREQ; i++) waitc[i] = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            r = req;
            exp_ack = '0; exp_busy = 1'b0;
            // One comparison occupies three clock edges: grant, capture, return to idle.
            if (stage == 0) begin
                if (r != '0) begin
                    g = rr_pick(r, last);
                    last = g;
                    exp_res = exp_flags(int'(a_in[g*WIDTH +: WIDTH]), int'(b_in[g*WIDTH +: WIDTH]));
                    exp_busy = 1'b1;
                    stage = 1;
                end
            end else if (stage == 1) begin
                exp_ack[g] = 1'b1;
                exp_busy = 1'b1;
                stage = 2;
            end else begin
                stage = 0;
            end
            checks++; if (ack !== exp_ack) begin failures++; ack_errs++; if (ack_errs < 10) $display("FAIL rand_ack cyc=%0d got=%b exp=%b", cyc, ack, exp_ack); end
            checks++; if (busy !== exp_busy) begin failures++; ack_errs++; if (ack_errs < 10) $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
            if (exp_ack != '0) begin
                checks++; if ({res_eq, res_gt, res_lt} !== exp_res) begin failures++; ack_errs++; if (ack_errs < 10) $display("FAIL rand_res cyc=%0d got=%b exp=%b", cyc, {res_eq, res_gt, res_lt}, exp_res); end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && !ack[i]) waitc[i]++; else waitc[i] = 0;
                if (waitc[i] > maxwait) maxwait = waitc[i];
                if (ack[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    a = int'($urandom_range(0, 127));
                    b = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 127));
                    set_op(i, a, b);
                    req[i] = 1'b1;
                end else if (stage == 1 && i == g && $urandom_range(0, 1) == 1) begin
                    set_op(i, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
                end
            end
        end
        checks++; if (maxwait > 3 * NREQ) begin failures++; $display("FAIL rand_starve got=%0d exp<=%0d", maxwait, 3 * NREQ); end
`ifdef COMPMAG_ARB_CHECK_EN
        checks++; if (err !== 1'b0 || err_cnt !== 8'd0) begin failures++; $display("FAIL rand_noerr got=%b/%0d exp=0/0", err, err_cnt); end
`endif
        req = '0;
        repeat (3) @(negedge clk);
    endtask

`ifdef COMPMAG_ARB_CHECK_EN
    task automatic test_check();
        logic [NREQ-1:0] seen; int cyc, bcyc;
        do_reset();
        force_en = 1'b1; force_flags = 3'b110;
        set_op(0, 5, 5);
        req = 4'b0001;
        wait_ack(seen, cyc, bcyc);
        req = '0;
        checks++; if (seen !== 4'b0001) begin failures++; $display("FAIL chk_ack got=%b exp=0001", seen); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL chk_err got=%b exp=1", err); end
        checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL chk_cnt got=%0d exp=1", err_cnt); end
        checks++; if ({res_eq, res_gt, res_lt} !== 3'b110) begin failures++; $display("FAIL chk_res got=%b exp=110", {res_eq, res_gt, res_lt}); end
        force_en = 1'b0;
        set_op(1, 9, 2);
        req = 4'b0010;
        wait_ack(seen, cyc, bcyc);
        req = '0;
        checks++; if (err !== 1'b1 || err_cnt !== 8'd1) begin failures++; $display("FAIL chk_sticky got=%b/%0d exp=1/1", err, err_cnt); end
        @(negedge clk);
    endtask
`endif

    initial begin
        rst_n = 1'b1; req = '0; a_in = '0; b_in = '0; force_en = 1'b0; force_flags = '0;
        test_reset();
        test_single();
        test_equal();
        test_all_four();
        test_fairness();
        test_reset_mid();
        test_random();
`ifdef COMPMAG_ARB_CHECK_EN
        test_check();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
